// File: rtl/furv_pkg.sv
// ---------------------------------------------------------------------------
// furv_pkg -- shared types and constants for the bus_arbiter slice.
//   state_e : arbiter FSM states (IDLE / ACCESS / RESP)
//   owner_e : which requester owns the outstanding transaction
//   DEF_*   : default widths and timeout used as parameter defaults
// ---------------------------------------------------------------------------
package furv_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned WAIT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage : furv_pkg

// File: rtl/arb_select.sv
// ---------------------------------------------------------------------------
// arb_select -- picks one of two requesters.
//   if_req_i : fetch-port request
//   d_req_i  : data-port request
//   last_i   : port granted most recently (used only for round-robin ties)
//   gnt_o    : one-hot selection, bit 1 = data port, bit 0 = fetch port
//
// Build option: define BUS_ARBITER_ROUND_ROBIN_EN to break ties in favour of
// the port not granted last; otherwise the data port always wins a tie.
// ---------------------------------------------------------------------------
module arb_select
  import furv_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    gnt_o = 2'b00;
    if (if_req_i && d_req_i) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      gnt_o = (last_i == OWN_D) ? 2'b01 : 2'b10;
`else
      gnt_o = 2'b10;
`endif
    end else begin
      gnt_o = {d_req_i, if_req_i};
    end
  end

`ifndef BUS_ARBITER_ROUND_ROBIN_EN
  // Fixed priority has no use for the history input.
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule : arb_select

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter -- shares one single-port memory between an instruction-fetch
// port and a data port, one transaction outstanding at a time.
//   clk, rst_n                    : clock, async active-low reset
//   if_req/if_addr                : fetch read request
//   if_gnt/if_rvalid/if_err/if_rdata : fetch grant, response, timeout, data
//   d_req/d_we/d_addr/d_wdata     : data-port request
//   d_gnt/d_rvalid/d_err/d_rdata  : data-port grant, response, timeout, data
//   mem_req/mem_we/mem_addr/mem_wdata : memory request
//   mem_ready/mem_rdata           : memory completion and read data
// Parameters: DATA_W, ADDR_W, TIMEOUT (1..255 ACCESS cycles before error).
// Build option: BUS_ARBITER_ROUND_ROBIN_EN (tie policy, see arb_select).
// ---------------------------------------------------------------------------
module bus_arbiter
  import furv_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  state_e                  state_q;
  owner_e                  owner_q;
  owner_e                  last_q;
  logic                    run_q;
  logic                    mem_req_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    rvalid_q;
  logic                    err_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;

  logic [1:0]              sel;
  logic                    arb_open;

  // In the fixed-priority build last_q has no load and is trimmed away.
  arb_select u_arb_select (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .last_i   (last_q),
    .gnt_o    (sel)
  );

  // run_q keeps arbitration closed until the first edge after reset release,
  // so a grant can never be seen before that edge.
  assign arb_open = run_q && (state_q == ST_IDLE);
  assign if_gnt   = arb_open & sel[0];
  assign d_gnt    = arb_open & sel[1];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & we_q;
  assign mem_addr  = mem_req_q ? addr_q  : '0;
  assign mem_wdata = mem_req_q ? wdata_q : '0;

  assign if_rvalid = rvalid_q && (owner_q == OWN_IF);
  assign if_err    = err_q    && (owner_q == OWN_IF);
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rvalid  = rvalid_q && (owner_q == OWN_D);
  assign d_err     = err_q    && (owner_q == OWN_D);
  assign d_rdata   = d_rvalid ? rdata_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      last_q    <= OWN_IF;
      run_q     <= 1'b0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      run_q    <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_open && (sel != 2'b00)) begin
            owner_q   <= sel[1] ? OWN_D : OWN_IF;
            last_q    <= sel[1] ? OWN_D : OWN_IF;
            addr_q    <= sel[1] ? d_addr : if_addr;
            // Fetches are always reads.
            we_q      <= sel[1] & d_we;
            wdata_q   <= sel[1] ? d_wdata : '0;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A ready in the final allowed cycle still completes normally.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            rdata_q   <= we_q ? '0 : mem_rdata;
            rvalid_q  <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + WAIT_CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter -- directed, table-driven bench for bus_arbiter (TIMEOUT=4).
// Inputs change 2 time units after the rising edge; outputs are sampled
// 4 units after it. Tie-break expectations follow BUS_ARBITER_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          e_if_gnt;
    logic          e_if_rvalid;
    logic          e_if_err;
    logic [DW-1:0] e_if_rdata;
    logic          e_d_gnt;
    logic          e_d_rvalid;
    logic          e_d_err;
    logic [DW-1:0] e_d_rdata;
    logic          e_mem_req;
    logic          e_mem_we;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic apply(input vec_t v);
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_ready = v.mem_ready; mem_rdata = v.mem_rdata;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_gnt"},    if_gnt,    0);
    check({tag, " d_gnt"},     d_gnt,     0);
    check({tag, " if_rvalid"}, if_rvalid, 0);
    check({tag, " d_rvalid"},  d_rvalid,  0);
    check({tag, " if_err"},    if_err,    0);
    check({tag, " d_err"},     d_err,     0);
    check({tag, " mem_req"},   mem_req,   0);
    check({tag, " mem_we"},    mem_we,    0);
    check({tag, " mem_addr"},  mem_addr,  0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   got;
    int   ngrant;
    int   gnt_own[4];
    int   gnt_cyc[4];
    int   if_gnt_cnt;

    // ---- reset state, requests asserted during reset must not be granted
    if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
    #12;
    check_all_zero("reset");
    clear_inputs();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk);

    // ---- cycle-by-cycle vector table
    // fetch 0x100, ready in first ACCESS cycle
    v = '0; v.if_req = 1; v.if_addr = 'h100; v.e_if_gnt = 1; vecs.push_back(v);
    v = '0; v.mem_ready = 1; v.mem_rdata = 'h13;
    v.e_mem_req = 1; v.e_mem_addr = 'h100; vecs.push_back(v);
    v = '0; v.mem_ready = 1; v.mem_rdata = 'h77;
    v.e_if_rvalid = 1; v.e_if_rdata = 'h13; vecs.push_back(v);
    // data write, ready after 3 wait cycles; stray mem_ready in IDLE ignored
    v = '0; v.d_req = 1; v.d_we = 1; v.d_addr = 'h2000; v.d_wdata = 'hDEADBEEF;
    v.mem_ready = 1; v.mem_rdata = 'h77; v.e_d_gnt = 1; vecs.push_back(v);
    v = '0; v.e_mem_req = 1; v.e_mem_we = 1; v.e_mem_addr = 'h2000; v.e_mem_wdata = 'hDEADBEEF;
    vecs.push_back(v);
    // fetch arrives during ACCESS and must wait
    v.if_req = 1; v.if_addr = 'h44; vecs.push_back(v);
    vecs.push_back(v);
    v.mem_ready = 1; v.mem_rdata = 'hFFFFFFFF; vecs.push_back(v);
    v = '0; v.if_req = 1; v.if_addr = 'h44; v.e_d_rvalid = 1; vecs.push_back(v);
    v = '0; v.if_req = 1; v.if_addr = 'h44; v.e_if_gnt = 1; vecs.push_back(v);
    // data req pulses during ACCESS and drops before any grant
    v = '0; v.mem_ready = 1; v.mem_rdata = 'hA5A50001; v.d_req = 1; v.d_addr = 'h500;
    v.e_mem_req = 1; v.e_mem_addr = 'h44; vecs.push_back(v);
    v = '0; v.e_if_rvalid = 1; v.e_if_rdata = 'hA5A50001; vecs.push_back(v);
    v = '0; vecs.push_back(v);
    v = '0; v.mem_ready = 1; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #2;
      apply(vecs[i]);
      #2;
      check($sformatf("vec%0d if_gnt", i),    if_gnt,    vecs[i].e_if_gnt);
      check($sformatf("vec%0d if_rvalid", i), if_rvalid, vecs[i].e_if_rvalid);
      check($sformatf("vec%0d if_err", i),    if_err,    vecs[i].e_if_err);
      check($sformatf("vec%0d if_rdata", i),  if_rdata,  vecs[i].e_if_rdata);
      check($sformatf("vec%0d d_gnt", i),     d_gnt,     vecs[i].e_d_gnt);
      check($sformatf("vec%0d d_rvalid", i),  d_rvalid,  vecs[i].e_d_rvalid);
      check($sformatf("vec%0d d_err", i),     d_err,     vecs[i].e_d_err);
      check($sformatf("vec%0d d_rdata", i),   d_rdata,   vecs[i].e_d_rdata);
      check($sformatf("vec%0d mem_req", i),   mem_req,   vecs[i].e_mem_req);
      check($sformatf("vec%0d mem_we", i),    mem_we,    vecs[i].e_mem_we);
      check($sformatf("vec%0d mem_addr", i),  mem_addr,  vecs[i].e_mem_addr);
      check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
    end

    // ---- timeout: memory never answers
    @(posedge clk); #2;
    clear_inputs();
    d_req = 1; d_addr = 'h300; mem_rdata = 'hBAD0BAD0;
    #2;
    check("to d_gnt", d_gnt, 1);
    @(posedge clk); #2;
    d_req = 0;
    #2;
    check("to mem_req c0", mem_req, 1);
    for (int k = 1; k < TO; k++) begin
      @(posedge clk); #4;
      check($sformatf("to mem_req c%0d", k), mem_req, 1);
    end
    @(posedge clk); #4;
    check("to mem_req dropped", mem_req,  0);
    check("to d_rvalid",        d_rvalid, 1);
    check("to d_err",           d_err,    1);
    check("to d_rdata",         d_rdata,  0);
    check("to if_rvalid",       if_rvalid, 0);
    check("to if_err",          if_err,   0);
    @(posedge clk); #2;
    if_req = 1; if_addr = 'h88; mem_rdata = '0;
    #2;
    check("to idle if_gnt",   if_gnt,   1);
    check("to d_rvalid off",  d_rvalid, 0);
    check("to d_err off",     d_err,    0);
    @(posedge clk); #2;
    if_req = 0; mem_ready = 1; mem_rdata = 'h55;
    @(posedge clk); #4;
    check("to next if_rvalid", if_rvalid, 1);
    check("to next if_rdata",  if_rdata,  'h55);

    // ---- reset in the middle of ACCESS
    @(posedge clk); #2;
    clear_inputs();
    if_req = 1; if_addr = 'h600;
    #2;
    check("rst if_gnt", if_gnt, 1);
    @(posedge clk); #2;
    if_req = 0;
    #2;
    check("rst mem_req before", mem_req, 1);
    @(posedge clk); #2;
    d_req = 1; d_addr = 'h700;
    #1;
    rst_n = 0;
    #1;
    check("rst async mem_req", mem_req, 0);
    check("rst async mem_addr", mem_addr, 0);
    check("rst d_gnt held", d_gnt, 0);
    @(posedge clk); @(posedge clk); #2;
    mem_ready = 1; mem_rdata = 'h1234;
    rst_n = 1;
    #1;
    check("rst no gnt before edge", d_gnt, 0);
    check("rst mem_req after release", mem_req, 0);
    got = 0;
    for (int k = 0; k < 4 && got == 0; k++) begin
      @(posedge clk); #4;
      check($sformatf("rst no if_rvalid c%0d", k), if_rvalid, 0);
      if (d_gnt) got = 1;
    end
    check("rst regrant seen", got, 1);
    if (got == 1) begin
      @(posedge clk); #2;
      d_req = 0;
      #2;
      check("rst regrant mem_req",  mem_req,  1);
      check("rst regrant mem_addr", mem_addr, 'h700);
      @(posedge clk); #4;
      check("rst regrant d_rvalid", d_rvalid, 1);
      check("rst regrant d_rdata",  d_rdata,  'h1234);
      check("rst regrant if_rvalid", if_rvalid, 0);
    end

    // ---- simultaneous requests, four transactions
    do_reset();
    #2;
    if_req = 1; if_addr = 'h10; d_req = 1; d_addr = 'h20; mem_ready = 1; mem_rdata = 'h99;
    ngrant = 0;
    if_gnt_cnt = 0;
    for (int c = 0; c < 16 && ngrant < 4; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      #2;
      check($sformatf("tie one-hot c%0d", c), if_gnt & d_gnt, 0);
      if (if_gnt) if_gnt_cnt++;
      if (if_gnt || d_gnt) begin
        gnt_own[ngrant] = d_gnt ? 1 : 0;
        gnt_cyc[ngrant] = c;
        ngrant++;
      end
    end
    if_req = 0; d_req = 0;
    check("tie grant count", ngrant, 4);
    for (int g = 0; g < ngrant; g++) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      check($sformatf("tie grant%0d owner(1=D)", g), gnt_own[g], (g % 2 == 0) ? 1 : 0);
`else
      check($sformatf("tie grant%0d owner(1=D)", g), gnt_own[g], 1);
`endif
      if (g > 0)
        check($sformatf("tie grant%0d spacing", g), gnt_cyc[g] - gnt_cyc[g-1], 3);
    end
`ifndef BUS_ARBITER_ROUND_ROBIN_EN
    check("tie fixed if_gnt never", if_gnt_cnt, 0);
`endif
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bus_arbiter
